// File: rtl/x1_mem_sched_if.sv
// Bus bundle between the sharpx1 core, the ROM loader and the shared SRAM.
// The scheduler takes the slave view; the core/loader/memory side takes master.
interface x1_mem_sched_if #(
   parameter int AW = 17
);
   // Loader download stream
   logic          ioctl_download;
   logic [7:0]    ioctl_index;
   logic          ioctl_wr;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wait;
   // Z80 bus requester
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din;
   logic [7:0]    cpu_dout;
   logic          cpu_ack;
   logic          cpu_hold;
   // Single-port SRAM
   logic          mem_ce;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;
   // Status
   logic          load_done;
   logic          dl_err;

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait,
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      output cpu_dout, cpu_ack, cpu_hold,
      output mem_ce, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output load_done, dl_err
   );

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait,
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      input  cpu_dout, cpu_ack, cpu_hold,
      input  mem_ce, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  load_done, dl_err
   );
endinterface

// File: rtl/x1_mem_sched.sv
// SRAM scheduler for the sharpx1 core: arbitrates the single-port byte SRAM
// between the ROM download stream (IPL / font images) and the Z80 bus, and
// keeps the CPU in reset while images are loading plus a short tail.
module x1_mem_sched #(
   parameter int            AW        = 17,
   parameter logic [AW-1:0] IPL_BASE  = 17'h00000,
   parameter int            IPL_SIZE  = 4096,
   parameter logic [AW-1:0] FONT_BASE = 17'h10000,
   parameter int            FONT_SIZE = 8192,
   parameter int            RD_LAT    = 2,
   parameter int            POST_HOLD = 16
) (
   input  logic           clk_sys,
   input  logic           reset_n,
   x1_mem_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DL_WR  = 3'd1,
      ST_CPU_WR = 3'd2,
      ST_CPU_RD = 3'd3,
      ST_ACK    = 3'd4
   } state_t;

   localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int HW = (POST_HOLD > 0) ? $clog2(POST_HOLD + 1) : 1;
   localparam logic [RW-1:0] RD_LAST   = RW'(RD_LAT - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(POST_HOLD);
   localparam logic [24:0]   IPL_LIM   = 25'(IPL_SIZE);
   localparam logic [24:0]   FONT_LIM  = 25'(FONT_SIZE);

   state_t        state_q, state_d;
   logic [RW-1:0] rd_cnt_q, rd_cnt_d;
   logic [AW-1:0] lat_addr_q, lat_addr_d;
   logic [7:0]    lat_din_q, lat_din_d;
   logic [7:0]    cpu_dout_q, cpu_dout_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          mem_ce_q, mem_ce_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;

   logic          buf_valid_q, buf_valid_d;
   logic [AW-1:0] buf_addr_q, buf_addr_d;
   logic [7:0]    buf_data_q, buf_data_d;

   logic          dl_q;
   logic          hold_q, hold_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          map_ok_s, map_err_s;
   logic [AW-1:0] map_addr_s;
   logic          strobe_s, cap_s, err_evt_s, dl_rise_s, dl_fall_s;

   assign strobe_s  = bus.ioctl_download & bus.ioctl_wr;
   assign cap_s     = strobe_s & ~buf_valid_q & map_ok_s;
   // A strobe on a full buffer or to a known image past its end is lost.
   assign err_evt_s = strobe_s & (buf_valid_q | map_err_s);
   assign dl_rise_s = bus.ioctl_download & ~dl_q;
   assign dl_fall_s = ~bus.ioctl_download & dl_q;

   // Translate the loader image index/offset into an SRAM address.
   always_comb begin
      map_ok_s   = 1'b0;
      map_err_s  = 1'b0;
      map_addr_s = '0;
      case (bus.ioctl_index)
         8'd0: begin
            if (bus.ioctl_addr < IPL_LIM) begin
               map_ok_s   = 1'b1;
               map_addr_s = IPL_BASE + bus.ioctl_addr[AW-1:0];
            end else begin
               map_err_s  = 1'b1;
            end
         end
         8'd1: begin
            if (bus.ioctl_addr < FONT_LIM) begin
               map_ok_s   = 1'b1;
               map_addr_s = FONT_BASE + bus.ioctl_addr[AW-1:0];
            end else begin
               map_err_s  = 1'b1;
            end
         end
         default: begin
            map_ok_s   = 1'b0;
            map_err_s  = 1'b0;
         end
      endcase
   end

   // One-entry holding buffer: filled by a mapped strobe, drained by DL_WR.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      if (state_q == ST_DL_WR) begin
         buf_valid_d = 1'b0;
      end else if (cap_s) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = map_addr_s;
         buf_data_d  = bus.ioctl_dout;
      end else begin
         buf_valid_d = buf_valid_q;
      end
   end

   // Arbiter next state plus registered SRAM/CPU strobes for the entered state.
   always_comb begin
      state_d     = state_q;
      rd_cnt_d    = rd_cnt_q;
      lat_addr_d  = lat_addr_q;
      lat_din_d   = lat_din_q;
      cpu_dout_d  = cpu_dout_q;
      cpu_ack_d   = 1'b0;
      mem_ce_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = 8'h00;
      case (state_q)
         ST_IDLE: begin
            // A byte captured this very cycle already wins, so the loader
            // sees ioctl_wait for a single cycle when the bus is idle.
            if (buf_valid_q || cap_s) begin
               state_d = ST_DL_WR;
            end else if (bus.cpu_req) begin
               lat_addr_d = bus.cpu_addr;
               lat_din_d  = bus.cpu_din;
               rd_cnt_d   = '0;
               state_d    = bus.cpu_we ? ST_CPU_WR : ST_CPU_RD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DL_WR:  state_d = ST_IDLE;
         ST_CPU_WR: state_d = ST_ACK;
         ST_CPU_RD: begin
            if (rd_cnt_q == RD_LAST) begin
               cpu_dout_d = bus.mem_rdata;
               state_d    = ST_ACK;
            end else begin
               rd_cnt_d   = rd_cnt_q + RW'(1);
               state_d    = ST_CPU_RD;
            end
         end
         ST_ACK:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_DL_WR: begin
            mem_ce_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = buf_addr_d;
            mem_wdata_d = buf_data_d;
         end
         ST_CPU_WR: begin
            mem_ce_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = lat_addr_d;
            mem_wdata_d = lat_din_d;
         end
         ST_CPU_RD: begin
            mem_ce_d    = 1'b1;
            mem_addr_d  = lat_addr_d;
         end
         ST_ACK:    cpu_ack_d = 1'b1;
         default:   cpu_ack_d = 1'b0;
      endcase
   end

   // CPU hold, post-download countdown, completion pulse and sticky error.
   always_comb begin
      hold_d     = hold_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = 1'b0;
      err_d      = err_evt_s | (err_q & ~dl_rise_s);
      if (dl_rise_s) begin
         // A new download cancels any tail countdown in progress.
         hold_d     = 1'b1;
         hold_cnt_d = '0;
      end else if (dl_fall_s) begin
         if (POST_HOLD == 0) begin
            hold_d = 1'b0;
            done_d = 1'b1;
         end else begin
            hold_cnt_d = HOLD_LOAD;
         end
      end else if ((hold_cnt_q != '0) && !buf_valid_q && (state_q != ST_DL_WR)) begin
         // The tail only runs once the last byte has reached the SRAM.
         hold_cnt_d = hold_cnt_q - HW'(1);
         if (hold_cnt_q == HW'(1)) begin
            hold_d = 1'b0;
            done_d = 1'b1;
         end else begin
            hold_d = hold_q;
         end
      end else begin
         hold_cnt_d = hold_cnt_q;
      end
   end

   // Arbiter state and registered bus outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rd_cnt_q    <= '0;
         lat_addr_q  <= '0;
         lat_din_q   <= 8'h00;
         cpu_dout_q  <= 8'h00;
         cpu_ack_q   <= 1'b0;
         mem_ce_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         lat_addr_q  <= lat_addr_d;
         lat_din_q   <= lat_din_d;
         cpu_dout_q  <= cpu_dout_d;
         cpu_ack_q   <= cpu_ack_d;
         mem_ce_q    <= mem_ce_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Download holding buffer registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= 8'h00;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end

   // Download window edge detector, hold/tail and status registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dl_q       <= 1'b0;
         hold_q     <= 1'b0;
         hold_cnt_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         dl_q       <= bus.ioctl_download;
         hold_q     <= hold_d;
         hold_cnt_q <= hold_cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.ioctl_wait = buf_valid_q;
   assign bus.cpu_dout   = cpu_dout_q;
   assign bus.cpu_ack    = cpu_ack_q;
   assign bus.cpu_hold   = hold_q;
   assign bus.mem_ce     = mem_ce_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.load_done  = done_q;
   assign bus.dl_err     = err_q;

endmodule
